// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 16x oversample prescaler, mid-bit sampling,
// framing-error detection and a valid/ack output handshake with overrun flag.
module uart_rx (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] baud_rate,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned DIV48  = 469;
    localparam int unsigned DIV96  = 234;
    localparam int unsigned DIV192 = 117;
    localparam int unsigned DIV384 = 59;
    localparam int unsigned DIV_W  = 9;
    localparam int unsigned TICK_W = 4;
    localparam int unsigned BIT_W  = 3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic [1:0]        rx_sync;
    logic              rx_s;
    logic [2:0]        state, state_nxt;
    logic [DIV_W-1:0]  div, div_nxt;
    logic [DIV_W-1:0]  presc, presc_nxt;
    logic [TICK_W-1:0] tick_cnt, tick_nxt;
    logic [BIT_W-1:0]  bit_idx, bit_nxt;
    logic [7:0]        shift, shift_nxt;
    logic [7:0]        data_nxt;
    logic              valid_nxt, frame_err_nxt, overrun_nxt;
    logic              tick_c;

    function automatic logic [DIV_W-1:0] div_sel(input logic [1:0] sel);
        case (sel)
            2'd0:    div_sel = DIV_W'(DIV48);
            2'd1:    div_sel = DIV_W'(DIV96);
            2'd2:    div_sel = DIV_W'(DIV192);
            default: div_sel = DIV_W'(DIV384);
        endcase
    endfunction

    assign rx_s   = rx_sync[1];
    assign tick_c = (presc == div - DIV_W'(1));

    // State and datapath registers; the line synchronizer resets to idle-high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_sync   <= 2'b11;
            state     <= S_IDLE;
            div       <= '0;
            presc     <= '0;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_sync   <= {rx_sync[0], rx};
            state     <= state_nxt;
            div       <= div_nxt;
            presc     <= presc_nxt;
            tick_cnt  <= tick_nxt;
            bit_idx   <= bit_nxt;
            shift     <= shift_nxt;
            rx_data   <= data_nxt;
            rx_valid  <= valid_nxt;
            frame_err <= frame_err_nxt;
            overrun   <= overrun_nxt;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_nxt     = state;
        div_nxt       = div;
        presc_nxt     = tick_c ? '0 : presc + DIV_W'(1);
        tick_nxt      = tick_c ? tick_cnt + TICK_W'(1) : tick_cnt;
        bit_nxt       = bit_idx;
        shift_nxt     = shift;
        data_nxt      = rx_data;
        valid_nxt     = rx_valid;
        frame_err_nxt = 1'b0;
        overrun_nxt   = overrun;

        if (rx_ack && rx_valid) begin
            valid_nxt   = 1'b0;
            overrun_nxt = 1'b0;
        end

        case (state)
            S_IDLE: begin
                presc_nxt = '0;
                tick_nxt  = '0;
                if (!rx_s) begin
                    state_nxt = S_START;
                    div_nxt   = div_sel(baud_rate);
                end
            end
            S_START: begin
                if (tick_c && tick_cnt == TICK_W'(7)) begin
                    tick_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                // Tick counter wraps 15 -> 0 on its own, so each bit is 16 ticks.
                if (tick_c && tick_cnt == TICK_W'(15)) begin
                    shift_nxt = {rx_s, shift[7:1]};
                    bit_nxt   = bit_idx + BIT_W'(1);
                    if (bit_idx == BIT_W'(7)) begin
                        state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick_c && tick_cnt == TICK_W'(15)) begin
                    if (rx_s) begin
                        state_nxt = S_IDLE;
                        // A same-cycle ack frees the holding register for the new byte.
                        if (!rx_valid || rx_ack) begin
                            data_nxt  = shift;
                            valid_nxt = 1'b1;
                        end else begin
                            overrun_nxt = 1'b1;
                        end
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                presc_nxt = '0;
                tick_nxt  = '0;
                if (rx_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed/randomized bench for uart_rx: frames are driven bit-by-bit and the
// outputs are compared against a small transaction-level receiver model.
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] baud_rate;
    logic       rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    always #5 clk = ~clk;

    uart_rx dut (
        .clk       (clk),
        .resetn    (resetn),
        .baud_rate (baud_rate),
        .rx        (rx),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: rx_valid rising edges and cycles with frame_err high.
    int unsigned rise_cyc = 0;
    int unsigned rises = 0;
    int unsigned fe_cnt = 0;
    logic        valid_q = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rx_valid && !valid_q) begin
            rise_cyc = cyc;
            rises++;
        end
        valid_q = rx_valid;
        if (frame_err) fe_cnt++;
    end

    int tests = 0;
    int fails = 0;

    // Receiver model: holding register, valid, overrun and framing-error tally.
    logic [7:0]  m_data;
    bit          m_valid;
    bit          m_ovr;
    int unsigned m_fe;

    function automatic int unsigned div_of(input logic [1:0] b);
        case (b)
            2'd0:    return 469;
            2'd1:    return 234;
            2'd2:    return 117;
            default: return 59;
        endcase
    endfunction

    task automatic m_reset();
        m_data = 8'h00; m_valid = 0; m_ovr = 0;
    endtask

    task automatic m_frame(input logic [7:0] b, input bit stop, input bit ack_same);
        if (!stop) m_fe++;
        else if (!m_valid || ack_same) begin
            m_data = b; m_valid = 1; m_ovr = 0;
        end else m_ovr = 1;
    endtask

    task automatic m_ack();
        if (m_valid) begin m_valid = 0; m_ovr = 0; end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_data"}, 32'(rx_data), 32'(m_data));
        check({tag, "_valid"}, 32'(rx_valid), 32'(m_valid));
        check({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
        check({tag, "_fe_count"}, fe_cnt, m_fe);
    endtask

    // Valid must rise 2 sync cycles + 152 ticks*N + 1 register cycle after rx falls, +/-1.
    task automatic check_lat(input string tag, input int unsigned c0, input int unsigned n);
        int unsigned exp_lat;
        int unsigned obs_lat;
        exp_lat = 2 + 152 * n + 1;
        obs_lat = rise_cyc - c0;
        tests++;
        assert (obs_lat + 1 >= exp_lat && obs_lat <= exp_lat + 1) else begin
            fails++;
            $error("FAIL %s: observed latency %0d expected %0d +/-1", tag, obs_lat, exp_lat);
        end
    endtask

    // Drive one frame from a negedge; optional ack on the stop-sample cycle and baud change at bit chg_bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit ack_at_stop,
                              input int chg_bit, input logic [1:0] new_baud,
                              output int unsigned c0);
        logic [9:0]  f;
        int unsigned n;
        n  = div_of(baud_rate);
        f  = {stop, b, 1'b0};
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            if (i == chg_bit) baud_rate = new_baud;
            for (int j = 0; j < int'(16 * n); j++) begin
                @(negedge clk);
                if (ack_at_stop) rx_ack = (cyc == c0 + 152 * n + 2);
            end
        end
        rx_ack = 1'b0;
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        m_ack();
    endtask

    initial begin
        int unsigned c0;
        int unsigned c1;
        int unsigned r0;
        logic [7:0]  b1, b2, b3, b4, b5;

        rx = 1'b1; rx_ack = 1'b0; baud_rate = 2'd1; resetn = 1'b0;
        m_reset(); m_fe = 0;
        b1 = 8'($urandom_range(0, 255)); b2 = 8'($urandom_range(0, 255));
        b3 = 8'($urandom_range(0, 255)); b4 = 8'($urandom_range(0, 255));
        b5 = 8'($urandom_range(0, 255));

        repeat (3) @(negedge clk);
        check_state("reset_held");
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check_state("reset_released");

        // 9600 baud, 0xA5.
        baud_rate = 2'd1;
        r0 = rises;
        send_frame(8'hA5, 1'b1, 1'b0, -1, 2'd0, c0);
        m_frame(8'hA5, 1'b1, 1'b0);
        check("a5_rises", rises - r0, 1);
        check_lat("a5_latency", c0, div_of(2'd1));
        check_state("a5_rx");
        pulse_ack();
        check_state("a5_ack");

        // 4800 baud, 1000-cycle low glitch.
        baud_rate = 2'd0;
        r0 = rises;
        rx = 1'b0;
        repeat (1000) @(negedge clk);
        rx = 1'b1;
        repeat (8 * 469 + 1500) @(negedge clk);
        check("glitch_rises", rises - r0, 0);
        check_state("glitch");

        // 38400 baud, 0x3C with stop=0, then line held low two frames.
        baud_rate = 2'd3;
        r0 = rises;
        send_frame(8'h3C, 1'b0, 1'b0, -1, 2'd0, c0);
        m_frame(8'h3C, 1'b0, 1'b0);
        check_state("ferr_frame");
        repeat (2 * 160 * 59) @(negedge clk);
        check_state("ferr_break_hold");
        rx = 1'b1;
        repeat (50) @(negedge clk);
        check("ferr_rises", rises - r0, 0);
        check_state("ferr_release");

        // Back-to-back frames without ack: second byte is dropped.
        r0 = rises;
        send_frame(b1, 1'b1, 1'b0, -1, 2'd0, c0);
        m_frame(b1, 1'b1, 1'b0);
        send_frame(b2, 1'b1, 1'b0, -1, 2'd0, c1);
        m_frame(b2, 1'b1, 1'b0);
        check_lat("b2b_latency", c0, div_of(2'd3));
        check("b2b_rises", rises - r0, 1);
        check_state("b2b_overrun");
        pulse_ack();
        check_state("b2b_ack");
        repeat ($urandom_range(1, 40)) @(negedge clk);
        send_frame(b3, 1'b1, 1'b0, -1, 2'd0, c0);
        m_frame(b3, 1'b1, 1'b0);
        check_lat("third_latency", c0, div_of(2'd3));
        check_state("third_byte");

        // Ack on the exact stop-sample cycle of the following frame.
        r0 = rises;
        send_frame(b4, 1'b1, 1'b1, -1, 2'd0, c0);
        m_frame(b4, 1'b1, 1'b1);
        check("ack_same_rises", rises - r0, 0);
        check_state("ack_same_cycle");

        // Reset in the middle of data bit 4.
        rx = 1'b0;
        repeat (16 * 59) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b5[i];
            repeat (16 * 59) @(negedge clk);
        end
        rx = b5[4];
        repeat (8 * 59) @(negedge clk);
        resetn = 1'b0;
        #1;
        m_reset();
        check_state("midframe_reset");
        @(negedge clk);
        resetn = 1'b1;
        rx = 1'b1;
        repeat (20) @(negedge clk);

        // Clean 0x5A at 38400 with baud_rate switched to 4800 mid-frame.
        baud_rate = 2'd3;
        r0 = rises;
        send_frame(8'h5A, 1'b1, 1'b0, 4, 2'd0, c0);
        m_frame(8'h5A, 1'b1, 1'b0);
        check("post_reset_rises", rises - r0, 1);
        check_lat("post_reset_latency", c0, div_of(2'd3));
        check_state("post_reset_5a");
        pulse_ack();
        check_state("post_reset_ack");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
